// File: rtl/nibble_serial_add_ctrl.sv
// Wide adder built from a single 4-bit ripple slice.
// One nibble per clock, LSB first, valid/ready on both sides.
module nibble_serial_add_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             busy
);
  localparam int NIB = WIDTH / 4;
  localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IW-1:0] LAST = IW'(NIB - 1);

  if (WIDTH < 4 || (WIDTH % 4) != 0) begin : g_bad_width
    $error("WIDTH must be a multiple of 4 and at least 4");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             c_out_q, c_out_d;
  logic             carry_q, carry_d;
  logic [IW-1:0]    idx_q, idx_d;

  logic [3:0] nib_a;
  logic [3:0] nib_b;
  logic [3:0] nib_s;
  logic       cy;

  // Four full-adder cells rippling from the registered carry.
  always_comb begin
    nib_a = a_q[{idx_q, 2'b00} +: 4];
    nib_b = b_q[{idx_q, 2'b00} +: 4];
    nib_s = '0;
    cy    = carry_q;
    for (int i = 0; i < 4; i++) begin
      nib_s[i] = nib_a[i] ^ nib_b[i] ^ cy;
      cy = (nib_a[i] & nib_b[i]) |
           (cy & (nib_a[i] ^ nib_b[i]));
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    c_out_d = c_out_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          carry_d = c_in;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d[{idx_q, 2'b00} +: 4] = nib_s;
        carry_d = cy;
        if (idx_q == LAST) begin
          c_out_d = cy;
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      c_out_q <= 1'b0;
      carry_q <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      c_out_q <= c_out_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
    end
  end

  // Gated so the block never advertises ready while held in reset.
  assign in_ready  = (state_q == IDLE) && rst_n;
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == RUN) || (state_q == DONE);
  assign sum       = sum_q;
  assign c_out     = c_out_q;

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Scoreboard bench for nibble_serial_add_ctrl.
// Expected results queued on accept, checked on output handshake.
module tb_nibble_serial_add_ctrl;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic         c_in = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         in_ready;
  logic         out_valid;
  logic         c_out;
  logic         busy;
  logic [W-1:0] sum;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int acc_cyc[$];
  logic [W:0] sb_q[$];
  logic [W:0] sb_e;

  nibble_serial_add_ctrl #(.WIDTH(W)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .a(a),
    .b(b),
    .c_in(c_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum(sum),
    .c_out(c_out),
    .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        chk("sb_unexpected", 32'd1, 32'd0);
      end else begin
        sb_e = sb_q.pop_front();
        chk("sb_result", 32'({c_out, sum}), 32'(sb_e));
      end
    end
    if (rst_n && in_valid && in_ready) begin
      sb_q.push_back({1'b0, a} + {1'b0, b} + {{W{1'b0}}, c_in});
      acc_cyc.push_back(cyc);
    end
  end

  task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb,
                      input logic tc);
    int n;
    n = 0;
    @(posedge clk); #1;
    a = ta; b = tb; c_in = tc; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("accept_timeout", 32'(n < 50), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Counts edges from accept until out_valid; optionally pokes inputs.
  task automatic wait_out(output int lat, input bit poke);
    lat = 0;
    while (lat < 50) begin
      @(negedge clk);
      if (out_valid) break;
      lat++;
      if (poke) begin
        chk("in_ready_run", 32'(in_ready), 32'd0);
        in_valid = ~in_valid;
        a = W'($urandom);
      end
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb_q.size() != 0 || out_valid) && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", 32'(n < 60), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cycles=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    logic [W:0] e;
    logic [W-1:0] ra, rb;
    logic rc;

    #12;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_c_out", 32'(c_out), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("idle_in_ready", 32'(in_ready), 32'd1);

    send(16'h1234, 16'h0001, 1'b0);
    wait_out(lat, 1'b0);
    chk("latency", 32'(lat), 32'd4);
    chk("sum_1235", 32'(sum), 32'h1235);
    chk("busy_done", 32'(busy), 32'd1);
    drain();

    send(16'hFFFF, 16'h0001, 1'b0);
    wait_out(lat, 1'b0);
    chk("ripple_sum", 32'(sum), 32'h0000);
    chk("ripple_cout", 32'(c_out), 32'd1);
    drain();
    send(16'h8000, 16'h8000, 1'b0);
    wait_out(lat, 1'b0);
    chk("top_cout", 32'(c_out), 32'd1);
    drain();
    send(16'h0000, 16'h0000, 1'b1);
    wait_out(lat, 1'b0);
    chk("cin_sum", 32'(sum), 32'h0001);
    drain();
    send(16'hFFFF, 16'hFFFF, 1'b1);
    wait_out(lat, 1'b0);
    chk("max_sum", 32'({c_out, sum}), 32'h1FFFF);
    drain();

    out_ready = 1'b0;
    e = {1'b0, 16'hA5A5} + {1'b0, 16'h5A5B} + 17'd1;
    send(16'hA5A5, 16'h5A5B, 1'b1);
    wait_out(lat, 1'b1);
    chk("bp_latency", 32'(lat), 32'd4);
    for (int i = 0; i < 5; i++) begin
      in_valid = ~in_valid;
      a = W'($urandom);
      @(negedge clk);
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_result", 32'({c_out, sum}), 32'(e));
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b1;
    drain();

    acc_cyc.delete();
    for (int i = 0; i < 3; i++) begin
      int n;
      ra = W'($urandom);
      rb = W'($urandom);
      rc = 1'($urandom);
      n = 0;
      if (i == 0) begin
        @(posedge clk); #1;
      end
      a = ra; b = rb; c_in = rc; in_valid = 1'b1;
      @(negedge clk);
      while (!in_ready && n < 50) begin
        @(negedge clk);
        n++;
      end
      chk("b2b_timeout", 32'(n < 50), 32'd1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    drain();
    chk("b2b_count", 32'(acc_cyc.size()), 32'd3);
    if (acc_cyc.size() == 3) begin
      chk("b2b_gap0", 32'(acc_cyc[1] - acc_cyc[0]), 32'd6);
      chk("b2b_gap1", 32'(acc_cyc[2] - acc_cyc[1]), 32'd6);
    end

    send(16'hABCD, 16'h1111, 1'b0);
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    sb_q.delete();
    chk("mid_rst_sum", 32'(sum), 32'd0);
    chk("mid_rst_cout", 32'(c_out), 32'd0);
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_ready", 32'(in_ready), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("post_rst_no_valid", 32'(out_valid), 32'd0);
      chk("post_rst_idle", 32'(in_ready), 32'd1);
    end
    send(16'h0F0F, 16'h00F1, 1'b0);
    wait_out(lat, 1'b0);
    chk("post_rst_sum", 32'({c_out, sum}), 32'h01000);
    drain();

    chk("sb_empty_end", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
